keypad_scan: RTL and testbench

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_scan.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_keypad_scan.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// ---------------------------------------------------------------------------
// keypad_scan
//
// Scans a 4x4 matrix keypad. The block drives all rows low while it waits
// for a key, so any closed key pulls a column low. It debounces the press,
// then walks the rows one at a time to find the key. It reports the key once
// and waits for a debounced release before it looks for the next key.
// All FSM activity advances only on a slow scan tick derived from clk.
//
// Parameters
//   SCAN_DIV   clk cycles per scan tick (2..65535)
//   DEB_TICKS  consecutive stable ticks needed for press / release (1..255)
//
// Ports
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   en         1 = scan, 0 = hold the block idle (rows released)
//   col_i      keypad columns, pulled up, low = key closed on a driven row
//   row_o      keypad row drive, active-low
//   key_valid  one-clk pulse when a new debounced key appears on key_code
//   key_code   last accepted key, row*4+col
//   key_down   high while the accepted key is held (until release debounce)
//   disp_data  eight hex digits of key history for the display driver
//
// Build option
//   KEYPAD_SCAN_HISTORY_EN  when defined, disp_data shifts in each accepted
//                           key code; when undefined disp_data is tied to 0
//                           and no history register exists.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module keypad_scan #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned DEB_TICKS = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [3:0]  col_i,
  output logic [3:0]  row_o,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_down,
  output logic [31:0] disp_data
);

  // FSM encoding
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PRESS_DEB = 3'd1;
  localparam logic [2:0] ST_SCAN      = 3'd2;
  localparam logic [2:0] ST_HELD      = 3'd3;
  localparam logic [2:0] ST_REL_DEB   = 3'd4;

  localparam logic [15:0] TICK_MAX = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  DEB_MAX  = 8'(DEB_TICKS);

  // Index of the lowest-numbered low column (caller guarantees one is low).
  function automatic logic [1:0] lowest_low_col(input logic [3:0] cols);
    logic [1:0] idx;
    if (!cols[0]) begin
      idx = 2'd0;
    end else if (!cols[1]) begin
      idx = 2'd1;
    end else if (!cols[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  logic [3:0]  sync1_q;
  logic [3:0]  sync2_q;
  logic [15:0] tick_cnt_q;
  logic [15:0] tick_cnt_d;
  logic        tick_s;
  logic        any_low_s;

  logic [2:0]  state_q;
  logic [2:0]  state_d;
  logic [1:0]  row_idx_q;
  logic [1:0]  row_idx_d;
  logic [7:0]  deb_cnt_q;
  logic [7:0]  deb_cnt_d;

  logic [3:0]  row_q;
  logic [3:0]  row_d;
  logic        key_valid_q;
  logic        key_valid_d;
  logic [3:0]  key_code_q;
  logic [3:0]  key_code_d;
  logic        key_down_q;
  logic        key_down_d;

  // Two-flop column synchroniser; idles at "all released".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= col_i;
      sync2_q <= sync1_q;
    end
  end

  assign any_low_s = (sync2_q != 4'hF);

  // Scan tick divider next state; held at zero while disabled.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (!en) begin
      tick_cnt_d = 16'd0;
    end else if (tick_cnt_q == TICK_MAX) begin
      tick_cnt_d = 16'd0;
    end else begin
      tick_cnt_d = tick_cnt_q + 16'd1;
    end
  end

  assign tick_s = en && (tick_cnt_q == TICK_MAX);

  // Scan tick divider register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q <= 16'd0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // FSM next state, row index, debounce count and key capture.
  always_comb begin
    state_d     = state_q;
    row_idx_d   = row_idx_q;
    deb_cnt_d   = deb_cnt_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;

    if (!en) begin
      state_d   = ST_IDLE;
      row_idx_d = 2'd0;
      deb_cnt_d = 8'd0;
    end else if (tick_s) begin
      case (state_q)
        ST_IDLE: begin
          if (any_low_s) begin
            // With a one-tick debounce the first low tick already qualifies.
            if (DEB_MAX == 8'd1) begin
              state_d   = ST_SCAN;
              row_idx_d = 2'd0;
              deb_cnt_d = 8'd0;
            end else begin
              state_d   = ST_PRESS_DEB;
              deb_cnt_d = 8'd1;
            end
          end else begin
            deb_cnt_d = 8'd0;
          end
        end

        ST_PRESS_DEB: begin
          if (any_low_s) begin
            if ((deb_cnt_q + 8'd1) >= DEB_MAX) begin
              state_d   = ST_SCAN;
              row_idx_d = 2'd0;
              deb_cnt_d = 8'd0;
            end else begin
              deb_cnt_d = deb_cnt_q + 8'd1;
            end
          end else begin
            state_d   = ST_IDLE;
            deb_cnt_d = 8'd0;
          end
        end

        ST_SCAN: begin
          if (any_low_s) begin
            // Rows are walked upward, so the first hit is the lowest row.
            key_code_d  = {row_idx_q, lowest_low_col(sync2_q)};
            key_valid_d = 1'b1;
            state_d     = ST_HELD;
            row_idx_d   = 2'd0;
          end else if (row_idx_q == 2'd3) begin
            state_d   = ST_IDLE;
            row_idx_d = 2'd0;
          end else begin
            row_idx_d = row_idx_q + 2'd1;
          end
        end

        ST_HELD: begin
          if (!any_low_s) begin
            if (DEB_MAX == 8'd1) begin
              state_d   = ST_IDLE;
              deb_cnt_d = 8'd0;
            end else begin
              state_d   = ST_REL_DEB;
              deb_cnt_d = 8'd1;
            end
          end else begin
            deb_cnt_d = 8'd0;
          end
        end

        ST_REL_DEB: begin
          if (!any_low_s) begin
            if ((deb_cnt_q + 8'd1) >= DEB_MAX) begin
              state_d   = ST_IDLE;
              deb_cnt_d = 8'd0;
            end else begin
              deb_cnt_d = deb_cnt_q + 8'd1;
            end
          end else begin
            // Any bounce restarts the release qualification.
            deb_cnt_d = 8'd0;
          end
        end

        default: begin
          state_d   = ST_IDLE;
          row_idx_d = 2'd0;
          deb_cnt_d = 8'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Registered outputs follow the next state so they line up with it.
  always_comb begin
    row_d      = 4'b0000;
    key_down_d = 1'b0;
    if (!en) begin
      row_d      = 4'b1111;
      key_down_d = 1'b0;
    end else if (state_d == ST_SCAN) begin
      row_d      = ~(4'b0001 << row_idx_d);
      key_down_d = 1'b0;
    end else begin
      row_d      = 4'b0000;
      key_down_d = (state_d == ST_HELD) || (state_d == ST_REL_DEB);
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      row_idx_q   <= 2'd0;
      deb_cnt_q   <= 8'd0;
      row_q       <= 4'b1111;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      key_down_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_idx_q   <= row_idx_d;
      deb_cnt_q   <= deb_cnt_d;
      row_q       <= row_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_down_q  <= key_down_d;
    end
  end

  assign row_o     = row_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_down  = key_down_q;

`ifdef KEYPAD_SCAN_HISTORY_EN
  logic [31:0] hist_q;
  logic [31:0] hist_d;

  // New key codes enter at the least-significant digit.
  always_comb begin
    hist_d = hist_q;
    if (key_valid_d) begin
      hist_d = {hist_q[27:0], key_code_d};
    end else begin
      hist_d = hist_q;
    end
  end

  // Key history register, updated on the edge that raises key_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= 32'h0000_0000;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign disp_data = hist_q;
`else
  assign disp_data = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_keypad_scan.sv
`timescale 1ns/1ps

module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  col_s;
  logic [3:0]  row_o;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_down;
  logic [31:0] disp_data;

  logic [15:0] keys = 16'h0000;   // bit r*4+c = key at row r, col c closed
  int n_cmp = 0;
  int n_bad = 0;
  int kv_count = 0;

  keypad_scan #(.SCAN_DIV(4), .DEB_TICKS(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .col_i     (col_s),
    .row_o     (row_o),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_down  (key_down),
    .disp_data (disp_data)
  );

  always #5 clk = ~clk;

  // Keypad matrix model: a closed key on a low row pulls its column low.
  always_comb begin
    col_s = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !row_o[r]) col_s[c] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (key_valid === 1'b1) kv_count++;
  end

  task automatic wait_kv(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (key_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_up(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (key_down === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; en = 1'b0; keys = 16'h0;
    repeat (3) @(negedge clk);
    n_cmp++; if (row_o !== 4'b1111) begin n_bad++; $display("FAIL rst_row: got %b want 1111", row_o); end
    n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", key_valid); end
    n_cmp++; if (key_code !== 4'h0) begin n_bad++; $display("FAIL rst_code: got %h want 0", key_code); end
    n_cmp++; if (key_down !== 1'b0) begin n_bad++; $display("FAIL rst_down: got %b want 0", key_down); end
    n_cmp++; if (disp_data !== 32'h0) begin n_bad++; $display("FAIL rst_disp: got %h want 0", disp_data); end
    en = 1'b1; reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (row_o !== 4'b0000) begin n_bad++; $display("FAIL idle_row: got %b want 0000", row_o); end
  endtask

  // Key (0,0) held across reset release: exact tick / debounce / scan latency.
  task automatic test_first_tick;
    int kv0;
    @(negedge clk); reset_n = 1'b0; keys = 16'h0001; en = 1'b1;
    @(negedge clk); reset_n = 1'b1;
    kv0 = kv_count;
    repeat (7) @(posedge clk); #1;
    n_cmp++; if (row_o !== 4'b0000) begin n_bad++; $display("FAIL pre_scan_row: got %b want 0000", row_o); end
    @(posedge clk); #1;
    n_cmp++; if (row_o !== 4'b1110) begin n_bad++; $display("FAIL first_scan_row: got %b want 1110", row_o); end
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL early_valid: got %b want 0", key_valid); end
    @(posedge clk); #1;
    n_cmp++; if (key_valid !== 1'b1) begin n_bad++; $display("FAIL valid_edge: got %b want 1", key_valid); end
    n_cmp++; if (key_code !== 4'h0) begin n_bad++; $display("FAIL code_00: got %h want 0", key_code); end
    n_cmp++; if (key_down !== 1'b1) begin n_bad++; $display("FAIL down_00: got %b want 1", key_down); end
    @(posedge clk); #1;
    n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL valid_width: got %b want 0", key_valid); end
    @(negedge clk); keys = 16'h0;
    begin
      bit up;
      wait_up(40, up);
      n_cmp++; if (up !== 1'b1) begin n_bad++; $display("FAIL release_00: got %b want 1", up); end
    end
    n_cmp++; if (kv_count - kv0 !== 1) begin n_bad++; $display("FAIL pulses_00: got %0d want 1", kv_count - kv0); end
  endtask

  task automatic test_single_press;
    int kv0; bit seen;
    repeat (8) @(negedge clk);
    kv0 = kv_count;
    keys = 16'h0200;                       // row 2 col 1
    wait_kv(60, seen);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL press9_seen: got %b want 1", seen); end
    n_cmp++; if (key_code !== 4'h9) begin n_bad++; $display("FAIL press9_code: got %h want 9", key_code); end
    repeat (72) @(negedge clk);
    n_cmp++; if (key_down !== 1'b1) begin n_bad++; $display("FAIL press9_held: got %b want 1", key_down); end
    n_cmp++; if (kv_count - kv0 !== 1) begin n_bad++; $display("FAIL press9_pulses: got %0d want 1", kv_count - kv0); end
    keys = 16'h0;
    repeat (4) @(negedge clk);
    n_cmp++; if (key_down !== 1'b1) begin n_bad++; $display("FAIL rel_early: got %b want 1", key_down); end
    repeat (8) @(negedge clk);
    n_cmp++; if (key_down !== 1'b0) begin n_bad++; $display("FAIL rel_late: got %b want 0", key_down); end
    repeat (20) @(negedge clk);
    n_cmp++; if (kv_count - kv0 !== 1) begin n_bad++; $display("FAIL press9_after: got %0d want 1", kv_count - kv0); end
  endtask

  task automatic test_bounce;
    int kv0;
    kv0 = kv_count;
    keys = 16'h0020;                       // row 1 col 1, low for one tick only
    repeat (4) @(negedge clk);
    keys = 16'h0;
    repeat (40) @(negedge clk);
    n_cmp++; if (kv_count !== kv0) begin n_bad++; $display("FAIL bounce_pulses: got %0d want %0d", kv_count, kv0); end
    n_cmp++; if (key_down !== 1'b0) begin n_bad++; $display("FAIL bounce_down: got %b want 0", key_down); end
    n_cmp++; if (row_o !== 4'b0000) begin n_bad++; $display("FAIL bounce_row: got %b want 0000", row_o); end
  endtask

  task automatic test_simultaneous;
    int kv0; bit seen; bit up;
    kv0 = kv_count;
    keys = 16'h1040;                       // row 1 col 2 and row 3 col 0
    wait_kv(60, seen);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL multi_seen: got %b want 1", seen); end
    n_cmp++; if (key_code !== 4'h6) begin n_bad++; $display("FAIL multi_code: got %h want 6", key_code); end
    repeat (40) @(negedge clk);
    keys = 16'h0;
    wait_up(40, up);
    n_cmp++; if (up !== 1'b1) begin n_bad++; $display("FAIL multi_release: got %b want 1", up); end
    repeat (20) @(negedge clk);
    n_cmp++; if (kv_count - kv0 !== 1) begin n_bad++; $display("FAIL multi_pulses: got %0d want 1", kv_count - kv0); end
    n_cmp++; if (key_code !== 4'h6) begin n_bad++; $display("FAIL multi_code_kept: got %h want 6", key_code); end
  endtask

  task automatic test_reset_mid_scan;
    int kv0; bit hit;
    kv0 = kv_count;
    keys = 16'h4000;                       // row 3 col 2
    hit = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (row_o === 4'b1110) begin hit = 1'b1; break; end
    end
    n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL reach_scan: got %b want 1", hit); end
    #1 reset_n = 1'b0;
    #1;
    n_cmp++; if (row_o !== 4'b1111) begin n_bad++; $display("FAIL async_row: got %b want 1111", row_o); end
    n_cmp++; if (key_code !== 4'h0) begin n_bad++; $display("FAIL async_code: got %h want 0", key_code); end
    keys = 16'h0;
    @(negedge clk); reset_n = 1'b1;
    repeat (60) @(negedge clk);
    n_cmp++; if (kv_count !== kv0) begin n_bad++; $display("FAIL abandoned_pulses: got %0d want %0d", kv_count, kv0); end
  endtask

  task automatic test_en_drop_held;
    int kv0; bit seen;
    kv0 = kv_count;
    keys = 16'h0008;                       // row 0 col 3
    wait_kv(60, seen);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL en_seen: got %b want 1", seen); end
    repeat (2) @(negedge clk);
    en = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (row_o !== 4'b1111) begin n_bad++; $display("FAIL en_row: got %b want 1111", row_o); end
    n_cmp++; if (key_down !== 1'b0) begin n_bad++; $display("FAIL en_down: got %b want 0", key_down); end
    n_cmp++; if (key_code !== 4'h3) begin n_bad++; $display("FAIL en_code: got %h want 3", key_code); end
    @(negedge clk); keys = 16'h0;
    repeat (3) @(negedge clk); en = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++; if (row_o !== 4'b0000) begin n_bad++; $display("FAIL en_resume_row: got %b want 0000", row_o); end
    n_cmp++; if (kv_count - kv0 !== 1) begin n_bad++; $display("FAIL en_pulses: got %0d want 1", kv_count - kv0); end
  endtask

  task automatic test_history;
    bit seen; bit up;
    logic [31:0] exp1;
    logic [31:0] exp3;
`ifdef KEYPAD_SCAN_HISTORY_EN
    exp1 = 32'h0000_0001;
    exp3 = 32'h0000_0123;
`else
    exp1 = 32'h0000_0000;
    exp3 = 32'h0000_0000;
`endif
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      repeat (8) @(negedge clk);
      keys = 16'h0;
      keys[k] = 1'b1;                      // row 0 col k -> code k
      wait_kv(60, seen);
      n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL hist_seen%0d: got %b want 1", k, seen); end
      if (k == 1) begin
        n_cmp++; if (disp_data !== exp1) begin n_bad++; $display("FAIL hist_first: got %h want %h", disp_data, exp1); end
      end
      repeat (10) @(negedge clk);
      keys = 16'h0;
      wait_up(40, up);
      n_cmp++; if (up !== 1'b1) begin n_bad++; $display("FAIL hist_release%0d: got %b want 1", k, up); end
    end
    n_cmp++; if (disp_data !== exp3) begin n_bad++; $display("FAIL hist_final: got %h want %h", disp_data, exp3); end
    n_cmp++; if (key_code !== 4'h3) begin n_bad++; $display("FAIL hist_code: got %h want 3", key_code); end
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_single_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid_scan();
    test_en_drop_held();
    test_history();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
